// File: rtl/led_ctrl_button.sv
`default_nettype none
// ============================================================================
// Module   : led_ctrl_button
// Function : Push-button front end for the LED blinker. It debounces the pin,
//            classifies short and long presses, and drives LED_ctrl through
//            an OFF/ON/BLINK mode controller.
// Revision : 1.0 - initial release
// ============================================================================
module led_ctrl_button #(
    parameter int BTN_ACTIVE_LOW    = 1,
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int LONG_PRESS_CYCLES = 25000000,
    parameter int BLINK_HALF_PERIOD = 6250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic       led_ctrl,
    output logic [1:0] mode,
    output logic       btn_level,
    output logic       short_pulse,
    output logic       long_pulse
);

    localparam int c_DEB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int c_HOLD_W  = $clog2(LONG_PRESS_CYCLES);
    localparam int c_BLINK_W = $clog2(BLINK_HALF_PERIOD);

    localparam logic [c_DEB_W-1:0]   c_DEB_LAST   = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST  = c_HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_HALF_PERIOD - 1);

    localparam logic c_ACT_LOW = (BTN_ACTIVE_LOW != 0);

    localparam logic [1:0] c_MODE_OFF   = 2'd0;
    localparam logic [1:0] c_MODE_ON    = 2'd1;
    localparam logic [1:0] c_MODE_BLINK = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_t;

    logic                 r_sync1;
    logic                 r_sync2;
    logic [c_DEB_W-1:0]   r_deb_cnt;
    logic [c_HOLD_W-1:0]  r_hold_cnt;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    state_t               r_state;

    logic                 w_pin;
    logic                 w_short_evt;
    logic                 w_long_evt;
    logic [1:0]           w_next_mode;

    // Normalise polarity so that 1 always means "pressed" from here on.
    assign w_pin = btn ^ c_ACT_LOW;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= w_pin;
            r_sync2 <= r_sync1;
        end
    end

    // The level only follows the pin after an uninterrupted disagreement run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb_cnt <= '0;
            btn_level <= 1'b0;
        end else if (r_sync2 == btn_level) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == c_DEB_LAST) begin
            r_deb_cnt <= '0;
            btn_level <= r_sync2;
        end else begin
            r_deb_cnt <= r_deb_cnt + c_DEB_W'(1);
        end
    end

    assign w_short_evt = (r_state == ST_HELD) && !btn_level;
    assign w_long_evt  = (r_state == ST_HELD) && btn_level && (r_hold_cnt == c_HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hold_cnt  <= '0;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
        end else begin
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (btn_level) begin
                        r_state    <= ST_HELD;
                        r_hold_cnt <= '0;
                    end
                end
                ST_HELD: begin
                    if (w_short_evt) begin
                        r_state     <= ST_IDLE;
                        short_pulse <= 1'b1;
                    end else if (w_long_evt) begin
                        r_state    <= ST_LONG;
                        long_pulse <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
                    end
                end
                ST_LONG: begin
                    // Held presses never auto-repeat; wait for release silently.
                    if (!btn_level) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_next_mode = mode;
        if (w_short_evt) begin
            w_next_mode = (mode == c_MODE_OFF) ? c_MODE_ON : c_MODE_OFF;
        end else if (w_long_evt) begin
            w_next_mode = (mode == c_MODE_BLINK) ? c_MODE_OFF : c_MODE_BLINK;
        end
    end

    // Every press event changes mode; a new mode always restarts the blink phase lit.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode        <= c_MODE_OFF;
            led_ctrl    <= 1'b0;
            r_blink_cnt <= '0;
        end else if (w_short_evt || w_long_evt) begin
            mode        <= w_next_mode;
            led_ctrl    <= (w_next_mode != c_MODE_OFF);
            r_blink_cnt <= '0;
        end else if (mode == c_MODE_BLINK) begin
            if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt <= '0;
                led_ctrl    <= ~led_ctrl;
            end else begin
                r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
